// File: rtl/bcd_digit_gen_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_gen_if
// Control and digit bus for bcd_digit_gen. The master side (controller or
// bench) drives the i_* controls; the slave side (the digit generator)
// drives the registered o_* outputs toward the 4-to-10 decoder.
// Optional: BCD_DIGIT_GEN_LOADERR_EN adds the sticky o_load_err flag.
// ---------------------------------------------------------------------------
interface bcd_digit_gen_if #(
    parameter int DIV_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic             i_up_dn;
    logic             i_load;
    logic [3:0]       i_load_val;
    logic [DIV_W-1:0] i_div;

    logic [3:0]       o_digit;
    logic             o_digit_en;
    logic             o_carry;
    logic             o_busy;
`ifdef BCD_DIGIT_GEN_LOADERR_EN
    logic             o_load_err;
`endif

    modport master (
`ifdef BCD_DIGIT_GEN_LOADERR_EN
        input  o_load_err,
`endif
        output i_start, i_stop, i_up_dn, i_load, i_load_val, i_div,
        input  o_digit, o_digit_en, o_carry, o_busy
    );

    modport slave (
`ifdef BCD_DIGIT_GEN_LOADERR_EN
        output o_load_err,
`endif
        input  i_start, i_stop, i_up_dn, i_load, i_load_val, i_div,
        output o_digit, o_digit_en, o_carry, o_busy
    );
endinterface

// File: rtl/bcd_digit_gen.sv
// ---------------------------------------------------------------------------
// bcd_digit_gen
// Sequential BCD digit source. A prescaler divides clk by (div+1) and each
// tick steps the digit up or down through 0-9; wraps raise a one-cycle
// carry so several digits can be chained. digit/digit_en feed the
// downstream 4-to-10 decoder (din/en). All outputs are registered.
// Optional: BCD_DIGIT_GEN_LOADERR_EN adds a sticky o_load_err flag set by
// out-of-range loads.
// ---------------------------------------------------------------------------
module bcd_digit_gen #(
    parameter int DIV_W      = 8,
    parameter bit WRAP_CARRY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    bcd_digit_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [3:0]       r_digit;
    logic [3:0]       w_digit_nxt;
    logic [3:0]       w_load_sat;
    logic             r_digit_en;
    logic             r_busy;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             w_wrap;
    logic             w_tick;

    // Tick when the prescaler has reached (or, after div shrank, passed) div.
    // A tick in the cycle that stop is sampled still counts: the state is
    // RUN for that whole cycle.
    assign w_tick     = (r_state == S_RUN) && (r_cnt >= bus.i_div);

    // Loads saturate so the decoder never sees codes 10-15.
    assign w_load_sat = (bus.i_load_val > 4'd9) ? 4'd9 : bus.i_load_val;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; stop always wins over start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.i_start && !bus.i_stop) w_state_nxt = S_RUN;
            S_RUN:  if (bus.i_stop)                 w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (bus.i_stop)       w_state_nxt = S_IDLE;
                else if (bus.i_start) w_state_nxt = S_RUN;
            end
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Prescaler next value: cleared in IDLE and on load, counts in RUN,
    // frozen in HOLD so a resume continues the interrupted period.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.i_load) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE:  w_cnt_nxt = '0;
                S_RUN:   w_cnt_nxt = w_tick ? '0 : (r_cnt + CNT_ONE);
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    // Digit next value and wrap detect; load overrides a same-cycle tick.
    always_comb begin
        w_digit_nxt = r_digit;
        w_wrap      = 1'b0;
        if (bus.i_load) begin
            w_digit_nxt = w_load_sat;
        end else if (w_tick) begin
            if (bus.i_up_dn) begin
                if (r_digit == 4'd9) begin
                    w_digit_nxt = 4'd0;
                    w_wrap      = 1'b1;
                end else begin
                    w_digit_nxt = r_digit + 4'd1;
                end
            end else begin
                if (r_digit == 4'd0) begin
                    w_digit_nxt = 4'd9;
                    w_wrap      = 1'b1;
                end else begin
                    w_digit_nxt = r_digit - 4'd1;
                end
            end
        end
        w_carry_nxt = w_wrap & WRAP_CARRY;
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nxt;
    end

    // Registered outputs; enable/busy follow the next state so they line up
    // with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit    <= 4'd0;
            r_digit_en <= 1'b0;
            r_busy     <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            r_digit    <= w_digit_nxt;
            r_digit_en <= (w_state_nxt != S_IDLE);
            r_busy     <= (w_state_nxt == S_RUN);
            r_carry    <= w_carry_nxt;
        end
    end

    assign bus.o_digit    = r_digit;
    assign bus.o_digit_en = r_digit_en;
    assign bus.o_busy     = r_busy;
    assign bus.o_carry    = r_carry;

`ifdef BCD_DIGIT_GEN_LOADERR_EN
    logic r_load_err;

    // Sticky out-of-range flag; any in-range load clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_load_err <= 1'b0;
        else if (bus.i_load) r_load_err <= (bus.i_load_val > 4'd9);
    end

    assign bus.o_load_err = r_load_err;
`endif

endmodule

// File: tb/tb_bcd_digit_gen.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_gen
// Self-checking bench for bcd_digit_gen. Expected digit steps (value, carry,
// spacing in cycles) are queued when stimulus is driven and checked as the
// DUT produces them. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_digit_gen;

    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bcd_digit_gen_if #(.DIV_W(DIV_W)) bus ();

    bcd_digit_gen #(.DIV_W(DIV_W), .WRAP_CARRY(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] d;
        logic       c;
        int         gap;
    } ev_t;

    ev_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic push_ev(input logic [3:0] d, input logic c, input int gap);
        ev_t e;
        e.d = d; e.c = c; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_in_rst: got digit=%0d en=%b carry=%b busy=%b, expected all 0",
                     bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy} !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got digit=%0d en=%b carry=%b busy=%b, expected all 0",
                         i, bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy);
            end
        end
`ifdef BCD_DIGIT_GEN_LOADERR_EN
        n_chk++;
        if (bus.o_load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_err: got %b, expected 0", bus.o_load_err);
        end
`endif
    endtask

    task automatic test_up_wrap();
        logic [3:0] last;
        int cyc, budget;
        ev_t e;
        bus.i_div = 8'd2; bus.i_up_dn = 1'b1; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_chk++;
        if (bus.o_digit_en !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_digit !== 4'd0) begin
            n_fail++;
            $display("FAIL up_start: got en=%b busy=%b digit=%0d, expected en=1 busy=1 digit=0",
                     bus.o_digit_en, bus.o_busy, bus.o_digit);
        end
        for (int d = 1; d <= 9; d++) push_ev(4'(d), 1'b0, 3);
        push_ev(4'd0, 1'b1, 3);
        last = bus.o_digit; cyc = 0; budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); cyc++; budget--;
            if (bus.o_digit !== last || bus.o_carry !== 1'b0) begin
                e = sb.pop_front();
                n_chk++;
                if (bus.o_digit !== e.d || bus.o_carry !== e.c || cyc != e.gap) begin
                    n_fail++;
                    $display("FAIL up_step: got digit=%0d carry=%b gap=%0d, expected digit=%0d carry=%b gap=%0d",
                             bus.o_digit, bus.o_carry, cyc, e.d, e.c, e.gap);
                end
                last = bus.o_digit; cyc = 0;
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL up_timeout: got %0d pending steps, expected 0", sb.size());
            sb.delete();
        end
        bus.i_stop = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.o_carry !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_digit_en !== 1'b1 || bus.o_digit !== 4'd0) begin
            n_fail++;
            $display("FAIL up_hold: got carry=%b busy=%b en=%b digit=%0d, expected carry=0 busy=0 en=1 digit=0",
                     bus.o_carry, bus.o_busy, bus.o_digit_en, bus.o_digit);
        end
        @(negedge clk);
        bus.i_stop = 1'b0;
        n_chk++;
        if (bus.o_digit_en !== 1'b0 || bus.o_digit !== 4'd0) begin
            n_fail++;
            $display("FAIL up_idle: got en=%b digit=%0d, expected en=0 digit=0", bus.o_digit_en, bus.o_digit);
        end
    endtask

    task automatic test_down_load();
        logic [3:0] last;
        int cyc, budget;
        ev_t e;
        bus.i_load_val = 4'd4; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        n_chk++;
        if (bus.o_digit !== 4'd4 || bus.o_digit_en !== 1'b0 || bus.o_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL dn_load_idle: got digit=%0d en=%b carry=%b, expected digit=4 en=0 carry=0",
                     bus.o_digit, bus.o_digit_en, bus.o_carry);
        end
        bus.i_up_dn = 1'b0; bus.i_div = 8'd0; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_chk++;
        if (bus.o_digit !== 4'd4 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dn_start: got digit=%0d busy=%b, expected digit=4 busy=1", bus.o_digit, bus.o_busy);
        end
        for (int d = 3; d >= 0; d--) push_ev(4'(d), 1'b0, 1);
        push_ev(4'd9, 1'b1, 1);
        last = bus.o_digit; cyc = 0; budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); cyc++; budget--;
            if (bus.o_digit !== last || bus.o_carry !== 1'b0) begin
                e = sb.pop_front();
                n_chk++;
                if (bus.o_digit !== e.d || bus.o_carry !== e.c || cyc != e.gap) begin
                    n_fail++;
                    $display("FAIL dn_step: got digit=%0d carry=%b gap=%0d, expected digit=%0d carry=%b gap=%0d",
                             bus.o_digit, bus.o_carry, cyc, e.d, e.c, e.gap);
                end
                last = bus.o_digit; cyc = 0;
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL dn_timeout: got %0d pending steps, expected 0", sb.size());
            sb.delete();
        end
        // stop is sampled while still in RUN, so that cycle's tick lands.
        bus.i_stop = 1'b1;
        @(negedge clk);
        n_chk++;
        if (bus.o_digit !== 4'd8 || bus.o_carry !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_digit_en !== 1'b1) begin
            n_fail++;
            $display("FAIL dn_hold: got digit=%0d carry=%b busy=%b en=%b, expected digit=8 carry=0 busy=0 en=1",
                     bus.o_digit, bus.o_carry, bus.o_busy, bus.o_digit_en);
        end
        @(negedge clk);
        bus.i_stop = 1'b0;
        n_chk++;
        if (bus.o_digit_en !== 1'b0 || bus.o_digit !== 4'd8) begin
            n_fail++;
            $display("FAIL dn_idle: got en=%b digit=%0d, expected en=0 digit=8", bus.o_digit_en, bus.o_digit);
        end
    endtask

    task automatic test_pause_resume();
        logic [3:0] last;
        int cyc, budget;
        ev_t e;
        bus.i_up_dn = 1'b1; bus.i_div = 8'd4; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        n_chk++;
        if (bus.o_busy !== 1'b0 || bus.o_digit_en !== 1'b1 || bus.o_digit !== 4'd8) begin
            n_fail++;
            $display("FAIL pr_hold: got busy=%b en=%b digit=%0d, expected busy=0 en=1 digit=8",
                     bus.o_busy, bus.o_digit_en, bus.o_digit);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.o_digit !== 4'd8 || bus.o_digit_en !== 1'b1) begin
                n_fail++;
                $display("FAIL pr_frozen[%0d]: got digit=%0d en=%b, expected digit=8 en=1",
                         i, bus.o_digit, bus.o_digit_en);
            end
        end
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        push_ev(4'd9, 1'b0, 2);
        last = bus.o_digit; cyc = 0; budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); cyc++; budget--;
            if (bus.o_digit !== last || bus.o_carry !== 1'b0) begin
                e = sb.pop_front();
                n_chk++;
                if (bus.o_digit !== e.d || bus.o_carry !== e.c || cyc != e.gap) begin
                    n_fail++;
                    $display("FAIL pr_resume: got digit=%0d carry=%b gap=%0d, expected digit=%0d carry=%b gap=%0d",
                             bus.o_digit, bus.o_carry, cyc, e.d, e.c, e.gap);
                end
                last = bus.o_digit; cyc = 0;
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pr_timeout: got %0d pending steps, expected 0", sb.size());
            sb.delete();
        end
        bus.i_stop = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_stop = 1'b0;
        n_chk++;
        if (bus.o_digit_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_digit !== 4'd9) begin
            n_fail++;
            $display("FAIL pr_idle: got en=%b busy=%b digit=%0d, expected en=0 busy=0 digit=9",
                     bus.o_digit_en, bus.o_busy, bus.o_digit);
        end
    endtask

    task automatic test_collide();
        logic [3:0] last;
        int cyc, budget;
        ev_t e;
        bus.i_load_val = 4'd5; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        bus.i_div = 8'd1; bus.i_up_dn = 1'b1; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        // This cycle the prescaler sits at div: a tick would give 6.
        bus.i_load_val = 4'd13; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        n_chk++;
        if (bus.o_digit !== 4'd9 || bus.o_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL col_load13: got digit=%0d carry=%b, expected digit=9 carry=0", bus.o_digit, bus.o_carry);
        end
`ifdef BCD_DIGIT_GEN_LOADERR_EN
        n_chk++;
        if (bus.o_load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL col_err_set: got %b, expected 1", bus.o_load_err);
        end
`endif
        push_ev(4'd0, 1'b1, 2);
        last = bus.o_digit; cyc = 0; budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk); cyc++; budget--;
            if (bus.o_digit !== last || bus.o_carry !== 1'b0) begin
                e = sb.pop_front();
                n_chk++;
                if (bus.o_digit !== e.d || bus.o_carry !== e.c || cyc != e.gap) begin
                    n_fail++;
                    $display("FAIL col_after: got digit=%0d carry=%b gap=%0d, expected digit=%0d carry=%b gap=%0d",
                             bus.o_digit, bus.o_carry, cyc, e.d, e.c, e.gap);
                end
                last = bus.o_digit; cyc = 0;
            end
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL col_timeout: got %0d pending steps, expected 0", sb.size());
            sb.delete();
        end
        bus.i_load_val = 4'd3; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        n_chk++;
        if (bus.o_digit !== 4'd3 || bus.o_carry !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL col_load3: got digit=%0d carry=%b busy=%b, expected digit=3 carry=0 busy=1",
                     bus.o_digit, bus.o_carry, bus.o_busy);
        end
`ifdef BCD_DIGIT_GEN_LOADERR_EN
        n_chk++;
        if (bus.o_load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL col_err_clr: got %b, expected 0", bus.o_load_err);
        end
`endif
    endtask

    task automatic test_stop_load();
        bus.i_stop = 1'b1; bus.i_load = 1'b1; bus.i_load_val = 4'd6;
        @(negedge clk);
        bus.i_load = 1'b0;
        n_chk++;
        if (bus.o_digit !== 4'd6 || bus.o_busy !== 1'b0 || bus.o_digit_en !== 1'b1 || bus.o_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL sl_both: got digit=%0d busy=%b en=%b carry=%b, expected digit=6 busy=0 en=1 carry=0",
                     bus.o_digit, bus.o_busy, bus.o_digit_en, bus.o_carry);
        end
        @(negedge clk);
        bus.i_stop = 1'b0;
        n_chk++;
        if (bus.o_digit_en !== 1'b0 || bus.o_digit !== 4'd6) begin
            n_fail++;
            $display("FAIL sl_idle: got en=%b digit=%0d, expected en=0 digit=6", bus.o_digit_en, bus.o_digit);
        end
    endtask

    task automatic test_async_reset();
        bus.i_load_val = 4'd7; bus.i_load = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        bus.i_div = 8'd20; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.o_digit !== 4'd7 || bus.o_busy !== 1'b1 || bus.o_digit_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre: got digit=%0d busy=%b en=%b, expected digit=7 busy=1 en=1",
                     bus.o_digit, bus.o_busy, bus.o_digit_en);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL ar_async: got digit=%0d en=%b carry=%b busy=%b, expected all 0",
                     bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy} !== 7'd0) begin
            n_fail++;
            $display("FAIL ar_idle: got digit=%0d en=%b carry=%b busy=%b, expected all 0",
                     bus.o_digit, bus.o_digit_en, bus.o_carry, bus.o_busy);
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_up_dn = 1'b1;
        bus.i_load  = 1'b0; bus.i_load_val = 4'd0; bus.i_div = '0;
        test_reset();
        test_up_wrap();
        test_down_load();
        test_pause_resume();
        test_collide();
        test_stop_load();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, expected finish");
        $fatal(1);
    end

endmodule
